// File: rtl/kernel_window_gen.sv
// Streaming KSIZE x KSIZE window generator with ready/valid on both sides.
// Keeps KSIZE-1 previous lines in circular line memories indexed by column.
module kernel_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 256,
    parameter int KSIZE      = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_valid,
    input  logic [DATA_WIDTH-1:0]               i_pixel,
    input  logic                                i_sof,
    output logic                                o_ready,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   o_window,
    output logic                                o_eol
);

    localparam int NLINES = KSIZE - 1;
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(KSIZE);
    localparam int PTR_W  = (NLINES > 1) ? $clog2(NLINES) : 1;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(KSIZE - 1);
    localparam logic [PTR_W-1:0] PTR_LAST      = PTR_W'(NLINES - 1);

    logic [DATA_WIDTH-1:0] line_mem [NLINES][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win      [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0] new_col  [KSIZE];

    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;
    logic [PTR_W-1:0] ptr, cur_ptr;
    logic [PTR_W-1:0] rd_line;
    logic             acc, qual, col_wrap;
    logic             valid_q, eol_q;

    assign o_ready = !valid_q || i_ready;
    assign acc     = i_valid && o_ready;
    assign o_valid = valid_q;
    assign o_eol   = eol_q;

    // A start-of-frame pixel is positioned as if the counters had just been cleared.
    always_comb begin
        cur_col  = i_sof ? '0 : col;
        cur_row  = i_sof ? '0 : row;
        cur_ptr  = i_sof ? '0 : ptr;
        col_wrap = (cur_col == COL_LAST);
        qual     = acc && (cur_row == ROW_LAST) && (cur_col >= COL_FIRST_WIN);
    end

    // New right column: line memories from oldest to newest, then the live pixel.
    always_comb begin
        new_col = '{default: '0};
        rd_line = '0;
        for (int unsigned k = 0; k < NLINES; k++) begin
            rd_line    = PTR_W'((32'(cur_ptr) + k) % NLINES);
            new_col[k] = line_mem[rd_line][cur_col];
        end
        new_col[KSIZE-1] = i_pixel;
    end

    always_ff @(posedge clk) begin
        if (acc)
            line_mem[cur_ptr][cur_col] <= i_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            ptr     <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            win     <= '{default: '{default: '0}};
        end else begin
            if (acc) begin
                if (col_wrap) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? cur_row : cur_row + 1'b1;
                    ptr <= (cur_ptr == PTR_LAST) ? '0 : cur_ptr + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                    ptr <= cur_ptr;
                end
                for (int unsigned r = 0; r < KSIZE; r++) begin
                    for (int unsigned c = 0; c < KSIZE - 1; c++)
                        win[r][c] <= win[r][c+1];
                    win[r][KSIZE-1] <= new_col[r];
                end
            end
            if (qual) begin
                valid_q <= 1'b1;
                eol_q   <= col_wrap;
            end else if (valid_q && i_ready) begin
                valid_q <= 1'b0;
                eol_q   <= 1'b0;
            end
        end
    end

    always_comb begin
        o_window = '0;
        for (int unsigned r = 0; r < KSIZE; r++)
            for (int unsigned c = 0; c < KSIZE; c++)
                o_window[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
    end

endmodule
